uart_loader: RTL



---
 rtl/uart_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_loader.sv
// uart_loader: on-chip end of a host-driven program-load protocol.
// Sits between uart_rx and uart_tx. It parses the frame
//    SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN payload bytes, CHK
// and writes each payload byte to memory as it arrives.
// CHK is the XOR of ADDR_H through the last payload byte.
// It then answers with a single ACK or NAK byte.
// The CPU is held in reset (o_loading) from SYNC until the response has gone out.
//
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   ce            clock enable; nothing advances while low
//   i_rx_byte     received byte
//   i_rx_avail    received-byte strobe
//   o_mem_addr    memory write address
//   o_mem_wdata   memory write data
//   o_mem_we      memory write strobe
//   o_tx_byte     response byte
//   o_tx_start    response request
//   i_tx_active   transmitter busy
//   o_loading     frame in progress / CPU reset
//   o_err         sticky error flag
//
// state      | meaning
// -----------+------------------------------------------------
// IDLE       | waiting for SYNC, other bytes ignored
// ADDR_H     | expecting address high byte
// ADDR_L     | expecting address low byte
// LEN_H      | expecting length high byte
// LEN_L      | expecting length low byte
// DATA       | receiving payload, one memory write per byte
// CHK        | expecting checksum byte
// RESP_START | requesting transmission of the response byte
// RESP_WAIT  | waiting for the transmitter to finish
module uart_loader #(
   parameter int          ADDR_W  = 16,
   parameter int          TIMEOUT = 100000,
   parameter logic [7:0]  SYNC    = 8'hA5,
   parameter logic [7:0]  ACK     = 8'h06,
   parameter logic [7:0]  NAK     = 8'h15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic [7:0]        i_rx_byte,
   input  logic              i_rx_avail,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_wdata,
   output logic              o_mem_we,
   output logic [7:0]        o_tx_byte,
   output logic              o_tx_start,
   input  logic              i_tx_active,
   output logic              o_loading,
   output logic              o_err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_H,
      S_ADDR_L,
      S_LEN_H,
      S_LEN_L,
      S_DATA,
      S_CHK,
      S_RESP_START,
      S_RESP_WAIT
   } state_t;

   state_t            state;
   logic [7:0]        hi_byte;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       remain;
   logic [7:0]        chk;
   logic [TW-1:0]     tmo_cnt;

   logic        accept;
   logic        in_frame;
   logic        tmo_hit;
   logic [15:0] rx_word;

   assign accept   = ce & i_rx_avail;
   assign in_frame = (state >= S_ADDR_H) && (state <= S_CHK);
   // The down-counter is reloaded on every accepted byte.
   // It expires on the TIMEOUT-th consecutive idle ce cycle.
   // A byte arriving on that same cycle takes priority over the expiry.
   assign tmo_hit  = in_frame && !accept && (tmo_cnt == '0);
   assign rx_word  = {hi_byte, i_rx_byte};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         hi_byte     <= '0;
         addr        <= '0;
         remain      <= '0;
         chk         <= '0;
         tmo_cnt     <= TMO_LOAD;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_we    <= 1'b0;
         o_tx_byte   <= '0;
         o_tx_start  <= 1'b0;
         o_loading   <= 1'b0;
         o_err       <= 1'b0;
      end else if (ce) begin
         o_mem_we <= 1'b0;

         if (accept)
            tmo_cnt <= TMO_LOAD;
         else if (in_frame && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - TW'(1);

         if (tmo_hit) begin
            o_tx_byte  <= NAK;
            o_err      <= 1'b1;
            o_tx_start <= 1'b1;
            state      <= S_RESP_START;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept && i_rx_byte == SYNC) begin
                     o_loading <= 1'b1;
                     o_err     <= 1'b0;
                     chk       <= '0;
                     state     <= S_ADDR_H;
                  end
               end
               S_ADDR_H: begin
                  if (accept) begin
                     hi_byte <= i_rx_byte;
                     chk     <= chk ^ i_rx_byte;
                     state   <= S_ADDR_L;
                  end
               end
               S_ADDR_L: begin
                  if (accept) begin
                     addr  <= rx_word[ADDR_W-1:0];
                     chk   <= chk ^ i_rx_byte;
                     state <= S_LEN_H;
                  end
               end
               S_LEN_H: begin
                  if (accept) begin
                     hi_byte <= i_rx_byte;
                     chk     <= chk ^ i_rx_byte;
                     state   <= S_LEN_L;
                  end
               end
               S_LEN_L: begin
                  if (accept) begin
                     remain <= rx_word;
                     chk    <= chk ^ i_rx_byte;
                     state  <= (rx_word == 16'd0) ? S_CHK : S_DATA;
                  end
               end
               S_DATA: begin
                  if (accept) begin
                     o_mem_we    <= 1'b1;
                     o_mem_addr  <= addr;
                     o_mem_wdata <= i_rx_byte;
                     addr        <= addr + ADDR_W'(1);
                     remain      <= remain - 16'd1;
                     chk         <= chk ^ i_rx_byte;
                     if (remain == 16'd1)
                        state <= S_CHK;
                  end
               end
               S_CHK: begin
                  if (accept) begin
                     if (i_rx_byte == chk) begin
                        o_tx_byte <= ACK;
                     end else begin
                        o_tx_byte <= NAK;
                        o_err     <= 1'b1;
                     end
                     o_tx_start <= 1'b1;
                     state      <= S_RESP_START;
                  end
               end
               S_RESP_START: begin
                  if (i_tx_active) begin
                     o_tx_start <= 1'b0;
                     state      <= S_RESP_WAIT;
                  end
               end
               S_RESP_WAIT: begin
                  if (!i_tx_active) begin
                     o_loading <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
